// File: rtl/cpu_bus_bridge.sv
// Bridges a CPU's split instruction/data memory ports onto a single request/ack bus.
// One CPU step walks IDLE -> [DATA] -> [FETCH] -> DONE, with a per-access timeout.
module cpu_bus_bridge #(
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_mem_rd_i,
   input  logic [31:0] instr_mem_addr_i,
   output logic [31:0] instr_mem_data_o,
   input  logic        data_mem_rd_i,
   input  logic        data_mem_wr_i,
   input  logic [31:0] data_mem_addr_i,
   input  logic [31:0] data_mem_data_i,
   input  logic [3:0]  byte_select_i,
   output logic [31:0] data_mem_data_o,
   output logic        mem_ready_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;

   logic busy;
   logic expired;
   logic finish;
   logic abort;

   assign busy    = (state_q == DATA) || (state_q == FETCH);
   assign expired = (cnt_q == CNT_LAST);
   assign finish  = busy && (bus_ack_i || expired);
   // Ack in the final wait cycle takes priority over the timeout.
   assign abort   = busy && !bus_ack_i && expired;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         instr_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (data_mem_rd_i || data_mem_wr_i) state_d = DATA;
            else if (instr_mem_rd_i)            state_d = FETCH;
            else                                state_d = DONE;
         end
         DATA: begin
            if (finish) state_d = instr_mem_rd_i ? FETCH : DONE;
         end
         FETCH: begin
            if (finish) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      instr_d = instr_q;
      data_d  = data_q;
      err_d   = err_q | abort;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (busy) begin
         cnt_d = cnt_q + 16'd1;
      end
      if (state_q == DATA && !data_mem_wr_i) begin
         if (bus_ack_i)  data_d = bus_rdata_i;
         else if (abort) data_d = '0;
      end
      if (state_q == FETCH) begin
         if (bus_ack_i)  instr_d = bus_rdata_i;
         else if (abort) instr_d = NOP_INSTR;
      end
   end

   always_comb begin
      mem_ready_o = (state_q == DONE);
      bus_req_o   = busy;
      bus_we_o    = 1'b0;
      bus_addr_o  = '0;
      bus_wdata_o = '0;
      bus_be_o    = '0;
      case (state_q)
         DATA: begin
            bus_addr_o = data_mem_addr_i;
            if (data_mem_wr_i) begin
               bus_we_o    = 1'b1;
               bus_wdata_o = data_mem_data_i;
               bus_be_o    = byte_select_i;
            end else begin
               bus_be_o = '1;
            end
         end
         FETCH: begin
            bus_addr_o = instr_mem_addr_i;
            bus_be_o   = '1;
         end
         default: ;
      endcase
   end

   assign instr_mem_data_o = instr_q;
   assign data_mem_data_o  = data_q;
   assign bus_err_o        = err_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge with TIMEOUT=4; stimulus driven and outputs sampled on falling edges.
module tb_cpu_bus_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_rd;
   logic [31:0] instr_addr;
   logic [31:0] instr_data;
   logic        data_rd, data_wr;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  bsel;
   logic        ready;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_bus_bridge #(.TIMEOUT(4), .NOP_INSTR(32'h0000_0013)) dut (
      .clk_i(clk), .rst_i(rst),
      .instr_mem_rd_i(instr_rd), .instr_mem_addr_i(instr_addr), .instr_mem_data_o(instr_data),
      .data_mem_rd_i(data_rd), .data_mem_wr_i(data_wr), .data_mem_addr_i(data_addr),
      .data_mem_data_i(data_wdata), .byte_select_i(bsel), .data_mem_data_o(data_rdata),
      .mem_ready_o(ready), .bus_req_o(req), .bus_we_o(we), .bus_addr_o(addr),
      .bus_wdata_o(wdata), .bus_be_o(be), .bus_rdata_i(rdata), .bus_ack_i(ack),
      .bus_err_o(err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Starts at the falling edge inside the first request cycle; ends inside the following state.
   task automatic bus_access(input int waits, input logic [31:0] rd, input logic [31:0] exp_addr,
                             input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      for (int i = 0; i < waits; i++) begin
         check("wait_req", 32'(req), 32'd1);
         check("wait_addr", addr, exp_addr);
         @(negedge clk);
      end
      check("acc_req", 32'(req), 32'd1);
      check("acc_addr", addr, exp_addr);
      check("acc_we", 32'(we), 32'(exp_we));
      check("acc_be", 32'(be), 32'(exp_be));
      check("acc_wdata", wdata, exp_wdata);
      check("acc_ready", 32'(ready), 32'd0);
      ack   = 1'b1;
      rdata = rd;
      @(negedge clk);
      ack   = 1'b0;
      rdata = '0;
   endtask

   task automatic timeout_access(input logic [31:0] exp_addr);
      for (int i = 0; i < 4; i++) begin
         check("to_req", 32'(req), 32'd1);
         check("to_addr", addr, exp_addr);
         @(negedge clk);
      end
   endtask

   task automatic end_step();
      instr_rd = 1'b0;
      data_rd  = 1'b0;
      data_wr  = 1'b0;
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      instr_rd = 1'b0; instr_addr = '0;
      data_rd = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; bsel = '0;
      rdata = '0; ack = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_req", 32'(req), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      check("rst_addr", addr, 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_be", 32'(be), 32'd0);
      check("rst_instr", instr_data, 32'd0);
      check("rst_data", data_rdata, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;

      // Fetch only, zero wait: ready on the third cycle.
      instr_rd = 1'b1; instr_addr = 32'h40;
      check("s1_idle_req", 32'(req), 32'd0);
      @(negedge clk);
      bus_access(0, 32'h0050_0093, 32'h40, 1'b0, 4'hF, 32'h0);
      check("s1_ready", 32'(ready), 32'd1);
      check("s1_req_drop", 32'(req), 32'd0);
      check("s1_instr", instr_data, 32'h0050_0093);
      end_step();

      // Store plus fetch, two waits each.
      data_wr = 1'b1; data_addr = 32'h100; data_wdata = 32'hAABB_CCDD; bsel = 4'b0011;
      instr_rd = 1'b1; instr_addr = 32'h44;
      @(negedge clk);
      bus_access(2, 32'h0, 32'h100, 1'b1, 4'b0011, 32'hAABB_CCDD);
      bus_access(2, 32'h0000_0093, 32'h44, 1'b0, 4'hF, 32'h0);
      check("s2_ready", 32'(ready), 32'd1);
      check("s2_instr", instr_data, 32'h0000_0093);
      check("s2_data_keep", data_rdata, 32'd0);
      end_step();

      // Load plus fetch: data first, both results during ready.
      data_rd = 1'b1; data_addr = 32'h200; instr_rd = 1'b1; instr_addr = 32'h48;
      @(negedge clk);
      bus_access(0, 32'h1234_5678, 32'h200, 1'b0, 4'hF, 32'h0);
      bus_access(0, 32'h0000_0013, 32'h48, 1'b0, 4'hF, 32'h0);
      check("s3_ready", 32'(ready), 32'd1);
      check("s3_data", data_rdata, 32'h1234_5678);
      check("s3_instr", instr_data, 32'h0000_0013);
      end_step();

      // Read and write both set: treated as write; no fetch leaves instr alone.
      data_rd = 1'b1; data_wr = 1'b1; data_addr = 32'h104; data_wdata = 32'h1122_3344; bsel = 4'b1100;
      @(negedge clk);
      bus_access(1, 32'hFFFF_FFFF, 32'h104, 1'b1, 4'b1100, 32'h1122_3344);
      check("s4_ready", 32'(ready), 32'd1);
      check("s4_data_keep", data_rdata, 32'h1234_5678);
      check("s4_instr_keep", instr_data, 32'h0000_0013);
      end_step();

      // Ack in the timeout cycle wins.
      instr_rd = 1'b1; instr_addr = 32'h4C;
      @(negedge clk);
      bus_access(3, 32'hDEAD_BEEF, 32'h4C, 1'b0, 4'hF, 32'h0);
      check("s5_ready", 32'(ready), 32'd1);
      check("s5_err", 32'(err), 32'd0);
      check("s5_instr", instr_data, 32'hDEAD_BEEF);
      end_step();

      // Fetch with no ack times out after four request cycles.
      instr_rd = 1'b1; instr_addr = 32'h50;
      @(negedge clk);
      timeout_access(32'h50);
      check("s6_req_drop", 32'(req), 32'd0);
      check("s6_ready", 32'(ready), 32'd1);
      check("s6_err", 32'(err), 32'd1);
      check("s6_instr_nop", instr_data, 32'h0000_0013);
      end_step();

      // Read timeout loads zero; fetch still proceeds; error stays set.
      data_rd = 1'b1; data_addr = 32'h300; instr_rd = 1'b1; instr_addr = 32'h54;
      @(negedge clk);
      timeout_access(32'h300);
      bus_access(0, 32'h00A0_0093, 32'h54, 1'b0, 4'hF, 32'h0);
      check("s7_ready", 32'(ready), 32'd1);
      check("s7_data_zero", data_rdata, 32'd0);
      check("s7_instr", instr_data, 32'h00A0_0093);
      check("s7_err_sticky", 32'(err), 32'd1);
      end_step();

      // Reset mid-DATA drops the request immediately.
      data_rd = 1'b1; data_addr = 32'h400;
      @(negedge clk);
      check("s8_req", 32'(req), 32'd1);
      rst = 1'b1;
      #1;
      check("s8_rst_req", 32'(req), 32'd0);
      check("s8_rst_addr", addr, 32'd0);
      check("s8_rst_be", 32'(be), 32'd0);
      check("s8_rst_instr", instr_data, 32'd0);
      check("s8_rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      data_rd = 1'b0;
      ack = 1'b1; rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("s8_ready_hi", 32'(ready), 32'd1);
         check("s8_data_ign", data_rdata, 32'd0);
         @(negedge clk);
         check("s8_ready_lo", 32'(ready), 32'd0);
         check("s8_req_lo", 32'(req), 32'd0);
      end
      ack = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_bus_bridge.md
CPU_BUS_BRIDGE -- requirements
Module: cpu_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum bus cycles to wait for bus_ack_i before aborting an access; legal range 1..65535.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction word returned when a fetch times out.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 instr_mem_rd_i  in  1  CPU fetch request.
REQ-006 instr_mem_addr_i  in  32  fetch address.
REQ-007 instr_mem_data_o  out  32  fetched instruction; valid while mem_ready_o=1.
REQ-008 data_mem_rd_i / data_mem_wr_i  in  1 each  CPU data read / write request.
REQ-009 data_mem_addr_i  in  32  data address.
REQ-010 data_mem_data_i  in  32  CPU store data.
REQ-011 byte_select_i  in  4  store byte enables.
REQ-012 data_mem_data_o  out  32  load data; valid while mem_ready_o=1.
REQ-013 mem_ready_o  out  1  one-cycle pulse that advances the CPU pipeline.
REQ-014 bus_req_o  out  1  bus request.
REQ-015 bus_we_o  out  1  1 = write.
REQ-016 bus_addr_o / bus_wdata_o  out  32 each  bus address / write data.
REQ-017 bus_be_o  out  4  bus byte enables.
REQ-018 bus_rdata_i  in  32  bus read data, sampled on bus_ack_i.
REQ-019 bus_ack_i  in  1  single-cycle access completion.
REQ-020 bus_err_o  out  1  sticky timeout flag.

Function
REQ-021 FSM states IDLE, DATA, FETCH, DONE; one CPU step = one pass IDLE..DONE.
REQ-022 IDLE lasts one cycle and samples requests: next DATA if data_mem_rd_i|data_mem_wr_i; else FETCH if instr_mem_rd_i; else DONE.
REQ-023 DATA: next FETCH if instr_mem_rd_i, else DONE, on bus_ack_i or timeout.
REQ-024 FETCH: next DONE on bus_ack_i or timeout.
REQ-025 DONE: mem_ready_o=1 for exactly this cycle; next IDLE.
REQ-026 Data access completes before fetch in the same step, so a store is visible to the fetch that follows it.
REQ-027 CPU inputs are stable while mem_ready_o=0; the bridge reads them live with no input registering.
REQ-028 bus_req_o=1 throughout DATA and FETCH; addr/we/wdata/be stay constant until the ack or timeout cycle.
REQ-029 bus_ack_i is accepted in the first request cycle (zero wait); a fetch-only step therefore takes 3 cycles and a data+fetch step 4 cycles minimum.
REQ-030 DATA write: bus_we_o=1, bus_wdata_o=data_mem_data_i, bus_be_o=byte_select_i.
REQ-031 DATA read and FETCH: bus_we_o=0, bus_be_o=4'b1111, bus_wdata_o=0.
REQ-032 If data_mem_rd_i and data_mem_wr_i are both 1, the access is a write.
REQ-033 bus_rdata_i is captured on ack into a holding register; a DATA read writes data_mem_data_o and a FETCH writes instr_mem_data_o; both hold until overwritten.
REQ-034 A step without a data read leaves data_mem_data_o unchanged.
REQ-035 A step without a fetch leaves instr_mem_data_o unchanged.
REQ-036 The wait counter clears on entry to DATA/FETCH and increments each cycle without ack; at count TIMEOUT-1 with no ack, the access aborts.
REQ-037 On abort: bus_req_o=0 in the next cycle and bus_err_o:=1.
REQ-038 A timed-out fetch loads NOP_INSTR and a timed-out read loads 32'h0.
REQ-039 When ack arrives in the timeout cycle, the ack wins and no error is raised.
REQ-040 bus_ack_i outside DATA/FETCH is ignored.

Reset
REQ-041 rst_i=1 forces state IDLE immediately, independent of clk_i.
REQ-042 Under reset: mem_ready_o=0, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, bus_be_o=0, instr_mem_data_o=0, data_mem_data_o=0, bus_err_o=0, counter=0.
REQ-043 Reset mid-access drops bus_req_o asynchronously; a late ack after reset release is ignored.

Verification
REQ-044 Fetch only, addr 0x40, ack zero-wait with rdata 0x00500093 -> bus_req_o high 1 cycle; mem_ready_o pulses on cycle 3; instr_mem_data_o=0x00500093.
REQ-045 Store to 0x100 with data 0xAABBCCDD, be 4'b0011, plus fetch at 0x44; ack after 2 waits each -> write cycle shows we=1, be=0011; then read of 0x44; ready pulses once after both complete.
REQ-046 Load from 0x200 (rdata 0x12345678) plus fetch at 0x48 (rdata 0x00000013) -> data access precedes fetch; both outputs are correct during the ready pulse.
REQ-047 TIMEOUT=4, fetch with no ack -> req drops after 4 cycles; bus_err_o=1 and stays 1; instr_mem_data_o=0x00000013; ready pulses.
REQ-048 rst_i asserted mid-DATA -> bus_req_o=0 the same cycle; all outputs take reset values; after release with no requests, ready pulses every 2 cycles.
